// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_W_DEF     = 5;
    // Branch flush depth selectors: squash IF/ID only, or IF/ID and ID/EX
    localparam int BR_FLUSH_IFID      = 1;
    localparam int BR_FLUSH_IFID_IDEX = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MD_WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for hazard performance statistics.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count events, holding at all-ones instead of wrapping
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_count <= '0;
        else if (i_inc && (r_count != '1))
            r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit_v2.sv
// Hazard controller for the 5-stage core: load-use bubbles, branch squash,
// MUL/DIV occupancy stalls, plus stall/flush statistics.
module hazard_unit_v2
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int LOAD_BUBBLES   = 1,
    parameter int BR_FLUSH_DEPTH = BR_FLUSH_IFID_IDEX,
    parameter int CNT_W          = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [REG_ADDR_W-1:0] i_id_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_id_rs2_addr,
    input  logic                  i_id_rs1_used,
    input  logic                  i_id_rs2_used,
    input  logic                  i_ex_mem_read,
    input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
    input  logic                  i_ex_br_taken,
    input  logic                  i_ex_md_start,
    input  logic                  i_ex_md_done,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_id_ex_write,
    output logic                  o_if_id_flush,
    output logic                  o_id_ex_flush,
    output logic [CNT_W-1:0]      o_stall_cycles,
    output logic [CNT_W-1:0]      o_flush_events
);

    localparam int BUB_W = 2;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [BUB_W-1:0] r_bub;
    logic [BUB_W-1:0] w_bub_nxt;
    logic             w_lu_hit;
    logic             w_br_acc;
    logic             w_pc_write;
    logic             w_if_id_write;
    logic             w_id_ex_write;
    logic             w_if_id_flush;
    logic             w_id_ex_flush;

    // x0 never carries a real dependency, and unused source fields are ignored
    assign w_lu_hit = i_ex_mem_read && (i_ex_rd_addr != '0) &&
                      ((i_id_rs1_used && (i_id_rs1_addr == i_ex_rd_addr)) ||
                       (i_id_rs2_used && (i_id_rs2_addr == i_ex_rd_addr)));

    // Next-state, bubble count and pipeline-control outputs
    always_comb begin
        w_pc_write    = 1'b1;
        w_if_id_write = 1'b1;
        w_id_ex_write = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;
        w_br_acc      = 1'b0;
        w_state_nxt   = r_state;
        w_bub_nxt     = r_bub;
        case (r_state)
            IDLE: begin
                if (i_ex_br_taken) begin
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = (BR_FLUSH_DEPTH == BR_FLUSH_IFID_IDEX);
                    w_br_acc      = 1'b1;
                end else if (i_ex_md_start) begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_write = 1'b0;
                    w_state_nxt   = i_ex_md_done ? IDLE : MD_WAIT;
                end else if (w_lu_hit) begin
                    // First bubble is issued from IDLE; the rest from LU_STALL
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    if (LOAD_BUBBLES > 1) begin
                        w_state_nxt = LU_STALL;
                        w_bub_nxt   = BUB_W'(LOAD_BUBBLES - 1);
                    end
                end
            end
            LU_STALL: begin
                if (i_ex_br_taken) begin
                    // The stalled instruction is on the wrong path; drop it
                    w_if_id_flush = 1'b1;
                    w_id_ex_flush = (BR_FLUSH_DEPTH == BR_FLUSH_IFID_IDEX);
                    w_br_acc      = 1'b1;
                    w_state_nxt   = IDLE;
                    w_bub_nxt     = '0;
                end else begin
                    w_pc_write    = 1'b0;
                    w_if_id_write = 1'b0;
                    w_id_ex_flush = 1'b1;
                    w_bub_nxt     = r_bub - 1'b1;
                    if (r_bub == BUB_W'(1))
                        w_state_nxt = IDLE;
                end
            end
            MD_WAIT: begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_id_ex_write = 1'b0;
                if (i_ex_md_done)
                    w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_bub_nxt   = '0;
            end
        endcase
        if (i_rst) begin
            w_pc_write    = 1'b1;
            w_if_id_write = 1'b1;
            w_id_ex_write = 1'b1;
            w_if_id_flush = 1'b0;
            w_id_ex_flush = 1'b0;
            w_br_acc      = 1'b0;
        end
    end

    // Registered FSM state and remaining-bubble count
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_bub   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_bub   <= w_bub_nxt;
        end
    end

    // MUL/DIV owns EX while waiting, so no branch can resolve there
    a_no_br_in_md: assert property (@(posedge i_clk) disable iff (i_rst)
        !((r_state == MD_WAIT) && i_ex_br_taken));

    assign o_pc_write    = w_pc_write;
    assign o_if_id_write = w_if_id_write;
    assign o_id_ex_write = w_id_ex_write;
    assign o_if_id_flush = w_if_id_flush;
    assign o_id_ex_flush = w_id_ex_flush;

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (~w_pc_write),
        .o_count (o_stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_inc   (w_br_acc),
        .o_count (o_flush_events)
    );

endmodule

// File: tb/tb_hazard_unit_v2.sv
// Bench for hazard_unit_v2: two configurations driven by the same inputs,
// each checked against a cycle-level model of the stall/flush rules.
module tb_hazard_unit_v2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rs1, rs2, rd;
    logic       rs1u, rs2u, mr, br, mds, mdd;

    // u0: 1 bubble, flush IF/ID+ID/EX, 16-bit counters
    // u1: 3 bubbles, flush IF/ID only, 4-bit counters
    logic        pc0, ifid0, idex0, iff0, idf0;
    logic        pc1, ifid1, idex1, iff1, idf1;
    logic [15:0] st0, fl0;
    logic [3:0]  st1, fl1;
    logic [4:0]  obs [2];

    assign obs[0] = {pc0, ifid0, idex0, iff0, idf0};
    assign obs[1] = {pc1, ifid1, idex1, iff1, idf1};

    hazard_unit_v2 #(.REG_ADDR_W(5), .LOAD_BUBBLES(1), .BR_FLUSH_DEPTH(2), .CNT_W(16)) u0 (
        .i_clk(clk), .i_rst(rst), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1u), .i_id_rs2_used(rs2u), .i_ex_mem_read(mr), .i_ex_rd_addr(rd),
        .i_ex_br_taken(br), .i_ex_md_start(mds), .i_ex_md_done(mdd),
        .o_pc_write(pc0), .o_if_id_write(ifid0), .o_id_ex_write(idex0),
        .o_if_id_flush(iff0), .o_id_ex_flush(idf0), .o_stall_cycles(st0), .o_flush_events(fl0));

    hazard_unit_v2 #(.REG_ADDR_W(5), .LOAD_BUBBLES(3), .BR_FLUSH_DEPTH(1), .CNT_W(4)) u1 (
        .i_clk(clk), .i_rst(rst), .i_id_rs1_addr(rs1), .i_id_rs2_addr(rs2),
        .i_id_rs1_used(rs1u), .i_id_rs2_used(rs2u), .i_ex_mem_read(mr), .i_ex_rd_addr(rd),
        .i_ex_br_taken(br), .i_ex_md_start(mds), .i_ex_md_done(mdd),
        .o_pc_write(pc1), .o_if_id_write(ifid1), .o_id_ex_write(idex1),
        .o_if_id_flush(iff1), .o_id_ex_flush(idf1), .o_stall_cycles(st1), .o_flush_events(fl1));

    int n_pass = 0;
    int n_tot  = 0;

    // Model: bubbles still owed, MUL/DIV busy flag, event counts
    int m_rem [2];
    bit m_md  [2];
    int m_st  [2];
    int m_fl  [2];

    function automatic int lb(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int cmax(int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic bit hit();
        return mr && (rd != 0) && ((rs1u && rs1 == rd) || (rs2u && rs2 == rd));
    endfunction

    // Expected {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_flush}
    function automatic logic [4:0] exp_out(int k);
        if (rst)        return 5'b11100;
        if (m_md[k])    return 5'b00000;
        if (br)         return {4'b1111, (k == 0)};
        if (m_rem[k] > 0) return 5'b00101;
        if (mds)        return 5'b00000;
        if (hit())      return 5'b00101;
        return 5'b11100;
    endfunction

    task automatic idle_in();
        rs1 = 0; rs2 = 0; rd = 0; rs1u = 0; rs2u = 0;
        mr = 0; br = 0; mds = 0; mdd = 0;
    endtask

    // Advance one clock and move the model along with it
    task automatic tick();
        logic [4:0] e [2];
        bit h;
        h = hit();
        for (int k = 0; k < 2; k++) e[k] = exp_out(k);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_rem[k] = 0; m_md[k] = 0; m_st[k] = 0; m_fl[k] = 0;
            end else begin
                if (!e[k][4] && m_st[k] < cmax(k)) m_st[k]++;
                if (m_md[k]) m_md[k] = !mdd;
                else if (br) begin
                    m_rem[k] = 0;
                    if (m_fl[k] < cmax(k)) m_fl[k]++;
                end
                else if (m_rem[k] > 0) m_rem[k]--;
                else if (mds) m_md[k] = !mdd;
                else if (h) m_rem[k] = lb(k) - 1;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1; idle_in();
        br = 1; mr = 1; rd = 3; rs1 = 3; rs1u = 1; mds = 1;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tot++;
            if (obs[k] !== 5'b11100) $display("FAIL reset_out u%0d: got %b want 11100", k, obs[k]);
            else n_pass++;
        end
        tick();
        tick();
        n_tot++;
        if ({st0, fl0, st1, fl1} !== 40'd0)
            $display("FAIL reset_cnt: got st0=%0d fl0=%0d st1=%0d fl1=%0d want 0", st0, fl0, st1, fl1);
        else n_pass++;
        rst = 0; idle_in();
    endtask

    task automatic test_load_use();
        int s0, s1;
        s0 = int'(st0); s1 = int'(st1);
        idle_in(); mr = 1; rd = 5; rs2 = 5; rs2u = 1; rs1 = 9; rs1u = 1;
        for (int i = 0; i < 5; i++) begin
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tot++;
                if (obs[k] !== exp_out(k)) $display("FAIL lu_out u%0d cyc%0d: got %b want %b", k, i, obs[k], exp_out(k));
                else n_pass++;
            end
            tick();
            mr = 0;
        end
        n_tot++;
        if (int'(st0) - s0 !== 1) $display("FAIL lu_stall1: got %0d want 1", int'(st0) - s0);
        else n_pass++;
        n_tot++;
        if (int'(st1) - s1 !== 3) $display("FAIL lu_stall3: got %0d want 3", int'(st1) - s1);
        else n_pass++;
    endtask

    task automatic test_no_stall();
        for (int i = 0; i < 3; i++) begin
            idle_in(); rs2 = 11; rs2u = 1;
            case (i)
                0: begin mr = 1; rd = 0; rs1 = 0; rs1u = 1; end
                1: begin mr = 1; rd = 7; rs1 = 7; rs1u = 0; end
                default: begin mr = 0; rd = 4; rs1 = 4; rs1u = 1; end
            endcase
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tot++;
                if (obs[k] !== 5'b11100) $display("FAIL no_stall u%0d pat%0d: got %b want 11100", k, i, obs[k]);
                else n_pass++;
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_branch();
        int f0, f1;
        f0 = int'(fl0); f1 = int'(fl1);
        // Branch wins over a simultaneous load-use
        idle_in(); br = 1; mr = 1; rd = 2; rs1 = 2; rs1u = 1;
        #1;
        n_tot++;
        if (obs[0] !== 5'b11111) $display("FAIL br_depth2: got %b want 11111", obs[0]);
        else n_pass++;
        n_tot++;
        if (obs[1] !== 5'b11110) $display("FAIL br_depth1: got %b want 11110", obs[1]);
        else n_pass++;
        tick();
        n_tot++;
        if (int'(fl0) - f0 !== 1 || int'(fl1) - f1 !== 1)
            $display("FAIL br_count: got %0d/%0d want 1/1", int'(fl0) - f0, int'(fl1) - f1);
        else n_pass++;
        // Load-use first, then a branch lands during u1's extra bubbles
        for (int i = 0; i < 3; i++) begin
            idle_in();
            if (i == 0) begin mr = 1; rd = 6; rs2 = 6; rs2u = 1; end
            if (i == 1) br = 1;
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tot++;
                if (obs[k] !== exp_out(k)) $display("FAIL br_in_stall u%0d cyc%0d: got %b want %b", k, i, obs[k], exp_out(k));
                else n_pass++;
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_muldiv();
        int s0;
        s0 = int'(st0);
        for (int i = 0; i < 8; i++) begin
            idle_in();
            mds = (i == 0); mdd = (i == 6);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tot++;
                if (obs[k] !== ((i < 7) ? 5'b00000 : 5'b11100))
                    $display("FAIL md_wait u%0d cyc%0d: got %b want %b", k, i, obs[k], (i < 7) ? 5'b00000 : 5'b11100);
                else n_pass++;
            end
            tick();
        end
        n_tot++;
        if (int'(st0) - s0 !== 7) $display("FAIL md_stall7: got %0d want 7", int'(st0) - s0);
        else n_pass++;
        // Start and done together: a single stalled cycle
        for (int i = 0; i < 2; i++) begin
            idle_in(); mds = (i == 0); mdd = (i == 0);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tot++;
                if (obs[k] !== ((i == 0) ? 5'b00000 : 5'b11100))
                    $display("FAIL md_same u%0d cyc%0d: got %b", k, i, obs[k]);
                else n_pass++;
            end
            tick();
        end
        idle_in();
    endtask

    task automatic test_reset_mid_stall();
        idle_in(); mr = 1; rd = 8; rs1 = 8; rs1u = 1;
        tick();
        idle_in(); rst = 1;   // u1 now owes its 2nd bubble
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tot++;
            if (obs[k] !== 5'b11100) $display("FAIL rst_stall_force u%0d: got %b want 11100", k, obs[k]);
            else n_pass++;
        end
        tick();
        rst = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tot++;
            if (obs[k] !== 5'b11100) $display("FAIL rst_stall_after u%0d: got %b want 11100", k, obs[k]);
            else n_pass++;
        end
        n_tot++;
        if ({st0, fl0, st1, fl1} !== 40'd0)
            $display("FAIL rst_stall_cnt: got st0=%0d st1=%0d want 0", st0, st1);
        else n_pass++;
    endtask

    task automatic test_saturation();
        idle_in(); mds = 1; mdd = 1;
        for (int i = 0; i < 20; i++) tick();
        idle_in(); br = 1;
        for (int i = 0; i < 20; i++) tick();
        idle_in();
        #1;
        n_tot++;
        if (st1 !== 4'd15 || st0 !== 16'd20) $display("FAIL sat_stall: got %0d/%0d want 20/15", st0, st1);
        else n_pass++;
        n_tot++;
        if (fl1 !== 4'd15 || fl0 !== 16'd20) $display("FAIL sat_flush: got %0d/%0d want 20/15", fl0, fl1);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            br   = !(m_md[0] || m_md[1]) && ($urandom_range(0, 7) == 0);
            mds  = ($urandom_range(0, 9) == 0);
            mdd  = ($urandom_range(0, 2) == 0);
            mr   = $urandom_range(0, 1);
            rd   = 5'($urandom_range(0, 3));
            rs1  = 5'($urandom_range(0, 3));
            rs2  = 5'($urandom_range(0, 3));
            rs1u = $urandom_range(0, 1);
            rs2u = $urandom_range(0, 1);
            #1;
            for (int k = 0; k < 2; k++) begin
                n_tot++;
                if (obs[k] !== exp_out(k)) $display("FAIL rand_out u%0d cyc%0d: got %b want %b", k, i, obs[k], exp_out(k));
                else n_pass++;
            end
            n_tot++;
            if (int'(st0) !== m_st[0] || int'(st1) !== m_st[1])
                $display("FAIL rand_stall cyc%0d: got %0d/%0d want %0d/%0d", i, st0, st1, m_st[0], m_st[1]);
            else n_pass++;
            n_tot++;
            if (int'(fl0) !== m_fl[0] || int'(fl1) !== m_fl[1])
                $display("FAIL rand_flush cyc%0d: got %0d/%0d want %0d/%0d", i, fl0, fl1, m_fl[0], m_fl[1]);
            else n_pass++;
            tick();
        end
        rst = 0; idle_in();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_rem[k] = 0; m_md[k] = 0; m_st[k] = 0; m_fl[k] = 0;
        end
        idle_in();
        test_reset();
        test_load_use();
        test_no_stall();
        test_branch();
        test_muldiv();
        test_reset_mid_stall();
        test_saturation();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
